// File: rtl/boot_pkg.sv
// boot_pkg: shared types and constants for the boot loader.
// Used by boot_loader and word_packer.
package boot_pkg;

   localparam int BOOT_LEN_W      = 16;
   localparam int BOOT_WORD_BYTES = 4;

   typedef enum logic [2:0] {
      BOOT_IDLE   = 3'd0,
      BOOT_LEN_HI = 3'd1,
      BOOT_DATA   = 3'd2,
      BOOT_WRITE  = 3'd3,
      BOOT_CHECK  = 3'd4,
      BOOT_DONE   = 3'd5,
      BOOT_ERROR  = 3'd6
   } boot_state_t;

   // States in which a stream byte may be taken.
   function automatic logic boot_takes_byte(input boot_state_t s);
      return (s == BOOT_IDLE) || (s == BOOT_LEN_HI) ||
             (s == BOOT_DATA) || (s == BOOT_CHECK);
   endfunction

endpackage

// File: rtl/word_packer.sv
// word_packer: gathers stream bytes into a little-endian word.
// Byte k of a word lands in bits [8k+7:8k]; clear zeroes the buffer.
module word_packer
   import boot_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         clear,
   input  logic [7:0]                   din,
   output logic [8*BOOT_WORD_BYTES-1:0] word,
   output logic                         full
);

   localparam int LW = $clog2(BOOT_WORD_BYTES);

   logic [8*BOOT_WORD_BYTES-1:0] buffer;
   logic [LW-1:0]                lane;

   // Buffer with the incoming byte merged into its lane.
   always_comb begin
      word = buffer;
      word[{lane, 3'b000} +: 8] = din;
   end

   assign full = push && (lane == LW'(BOOT_WORD_BYTES - 1));

   // Lane storage; cleared on reset or after the word is written.
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         buffer <= '0;
         lane   <= '0;
      end else if (push) begin
         buffer <= word;
         lane   <= lane + LW'(1);
      end
   end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: loads a length-prefixed byte image into memory, then
// releases the core. Optional trailing checksum: BOOT_CHECKSUM_EN.
module boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned MAX_BYTES = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic                  Clk,
   input  logic                  reset,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [31:0]           mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  mem_wr,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error,
   output logic [BOOT_LEN_W-1:0] byte_count
);

   localparam logic [BOOT_LEN_W:0] MAX_N = (BOOT_LEN_W + 1)'(MAX_BYTES);

`ifdef BOOT_CHECKSUM_EN
   localparam boot_state_t ST_FINAL = BOOT_CHECK;
`else
   localparam boot_state_t ST_FINAL = BOOT_DONE;
`endif

   boot_state_t           state;
   boot_state_t           nxt;
   logic [7:0]            len_lo;
   logic [BOOT_LEN_W-1:0] len;
   logic [BOOT_LEN_W-1:0] len_in;
   logic [BOOT_LEN_W-1:0] word_index;
   logic                  take;
   logic                  push;
   logic                  last;
   logic                  full;
   logic [31:0]           word;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]            csum;
`endif

   assign take   = in_valid && in_ready;
   assign push   = take && (state == BOOT_DATA);
   assign len_in = {in_data, len_lo};
   assign last   = (byte_count + BOOT_LEN_W'(1)) == len;

   word_packer u_packer (
      .clk   (Clk),
      .reset (reset),
      .push  (push),
      .clear (state == BOOT_WRITE),
      .din   (in_data),
      .word  (word),
      .full  (full)
   );

   // Next-state decision for the load sequence.
   always_comb begin
      nxt = state;
      unique case (state)
         BOOT_IDLE:
            if (take) nxt = BOOT_LEN_HI;
         BOOT_LEN_HI:
            if (take) begin
               if ({1'b0, len_in} > MAX_N)
                  nxt = BOOT_ERROR;
               else if (len_in == '0)
                  nxt = ST_FINAL;
               else
                  nxt = BOOT_DATA;
            end
         BOOT_DATA:
            if (push && (full || last)) nxt = BOOT_WRITE;
         BOOT_WRITE:
            nxt = (byte_count == len) ? ST_FINAL : BOOT_DATA;
         BOOT_CHECK: begin
`ifdef BOOT_CHECKSUM_EN
            if (take)
               nxt = (in_data == csum) ? BOOT_DONE : BOOT_ERROR;
`endif
         end
         BOOT_DONE:  nxt = BOOT_DONE;
         BOOT_ERROR: nxt = BOOT_ERROR;
         default:    nxt = BOOT_IDLE;
      endcase
   end

   // State register and status outputs derived from the next state.
   always_ff @(posedge Clk) begin
      if (!reset) begin
         state     <= BOOT_IDLE;
         in_ready  <= 1'b1;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= nxt;
         in_ready  <= boot_takes_byte(nxt);
         cpu_reset <= (nxt != BOOT_DONE);
         done      <= (nxt == BOOT_DONE);
         error     <= (nxt == BOOT_ERROR);
      end
   end

   // Length capture, counters and the memory write port.
   always_ff @(posedge Clk) begin
      if (!reset) begin
         len_lo     <= '0;
         len        <= '0;
         byte_count <= '0;
         word_index <= '0;
         mem_addr   <= BASE_ADDR;
         mem_wdata  <= '0;
         mem_wr     <= 1'b0;
      end else begin
         mem_wr <= (nxt == BOOT_WRITE);
         if (take && state == BOOT_IDLE)
            len_lo <= in_data;
         if (take && state == BOOT_LEN_HI)
            len <= len_in;
         if (push)
            byte_count <= byte_count + BOOT_LEN_W'(1);
         if (nxt == BOOT_WRITE) begin
            mem_addr  <= BASE_ADDR + 32'({word_index, 2'b00});
            mem_wdata <= word;
         end
         if (state == BOOT_WRITE)
            word_index <= word_index + BOOT_LEN_W'(1);
      end
   end

`ifdef BOOT_CHECKSUM_EN
   // Running 8-bit sum of payload bytes.
   always_ff @(posedge Clk) begin
      if (!reset)
         csum <= '0;
      else if (push)
         csum <= csum + in_data;
   end
`endif

endmodule
